// File: rtl/rf_pkg.sv
// Shared types and constants for the regfile_sb register file slice.
// Build option: define REGFILE_BYPASS_EN to enable write-to-read forwarding.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  // Register index and data word at the default configuration.
  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;

  // x0 is the architectural zero register.
  localparam int unsigned ZERO_REG = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// In-flight write scoreboard: one busy bit per architectural register.
// An issue marks the destination pending, a writeback retires it, and a
// flush drops every pending mark. x0 can never become busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_addr,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic          flush,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             iss_valid;

  // An issue to x0 is architecturally meaningless and never tracked.
  assign iss_valid = iss_en && (iss_addr != ZERO_ADDR);

  // Next busy vector: retire writes first, then let a new issue supersede
  // them, and finally let a flush wipe everything including that issue.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) begin
      busy_d[wr0_addr] = 1'b0;
    end
    if (wr1_en) begin
      busy_d[wr1_addr] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy vector register, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups for the two decode-stage source operands.
  always_comb begin
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
  end

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// RISC-V integer register file: two combinational read ports, two write
// ports (WB stage on port 0, load/long-latency return on port 1) and an
// in-flight write scoreboard feeding the hazard unit.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to the reads.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            rs1_busy_st;
  logic            rs2_busy_st;

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy_st),
    .rs2_busy (rs2_busy_st)
  );

  // Next register contents: port 1 is applied last so it wins a collision,
  // and x0 is forced back to zero whatever was written to it.
  always_comb begin
    regs_d = regs_q;
    if (wr0_en && (wr0_addr != ZERO_ADDR)) begin
      regs_d[wr0_addr] = wr0_data;
    end
    if (wr1_en && (wr1_addr != ZERO_ADDR)) begin
      regs_d[wr1_addr] = wr1_data;
    end
    regs_d[ZERO_REG] = '0;
  end

  // Storage array, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: stored value, optionally overridden by a same-cycle write.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs1_busy = rs1_busy_st;
`ifdef REGFILE_BYPASS_EN
    if (rs1_addr != ZERO_ADDR) begin
      if (wr1_en && (wr1_addr == rs1_addr)) begin
        rs1_data = wr1_data;
      end else if (wr0_en && (wr0_addr == rs1_addr)) begin
        rs1_data = wr0_data;
      end
      if (((wr1_en && (wr1_addr == rs1_addr)) ||
           (wr0_en && (wr0_addr == rs1_addr))) &&
          !(iss_en && (iss_addr == rs1_addr))) begin
        rs1_busy = 1'b0;
      end
    end
`endif
  end

  // Read port 2: same forwarding rules as port 1.
  always_comb begin
    rs2_data = regs_q[rs2_addr];
    rs2_busy = rs2_busy_st;
`ifdef REGFILE_BYPASS_EN
    if (rs2_addr != ZERO_ADDR) begin
      if (wr1_en && (wr1_addr == rs2_addr)) begin
        rs2_data = wr1_data;
      end else if (wr0_en && (wr0_addr == rs2_addr)) begin
        rs2_data = wr0_data;
      end
      if (((wr1_en && (wr1_addr == rs2_addr)) ||
           (wr0_en && (wr0_addr == rs2_addr))) &&
          !(iss_en && (iss_addr == rs2_addr))) begin
        rs2_busy = 1'b0;
      end
    end
`endif
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic compared against an array-based reference model.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic            wr0_en, wr1_en, iss_en, flush;
  logic [AW-1:0]   wr0_addr, wr1_addr, iss_addr;
  logic [XLEN-1:0] wr0_data, wr1_data;

  logic [XLEN-1:0] model_regs [NREGS];
  bit              model_busy [NREGS];

  int assertCount = 0;
  int failCount   = 0;

  regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every evaluation and every failure.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Return the whole architectural state of the model to its reset value.
  task automatic resetModel();
    for (int i = 0; i < NREGS; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
  endtask

  // Expected read data for one address given the current bench inputs.
  function automatic logic [XLEN-1:0] expectData(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return model_regs[a];
  endfunction

  // Expected busy flag for one address given the current bench inputs.
  function automatic logic expectBusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) &&
        !(iss_en && iss_addr == a)) return 1'b0;
`endif
    return model_busy[a];
  endfunction

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".rs1_data"}, rs1_data, expectData(rs1_addr));
    checkOutput({tag, ".rs2_data"}, rs2_data, expectData(rs2_addr));
    checkOutput({tag, ".rs1_busy"}, XLEN'(rs1_busy), XLEN'(expectBusy(rs1_addr)));
    checkOutput({tag, ".rs2_busy"}, XLEN'(rs2_busy), XLEN'(expectBusy(rs2_addr)));
  endtask

  // Advance the model by one clock edge using the architectural rules.
  task automatic updateModel();
    for (int r = 1; r < NREGS; r++) begin
      bit hitW0, hitW1, hitIss;
      hitW0  = wr0_en && (wr0_addr == r);
      hitW1  = wr1_en && (wr1_addr == r);
      hitIss = iss_en && (iss_addr == r);
      if (hitW1)      model_regs[r] = wr1_data;
      else if (hitW0) model_regs[r] = wr0_data;
      model_busy[r] = !flush && (hitIss || (model_busy[r] && !hitW0 && !hitW1));
    end
  endtask

  task automatic idleInputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  // Take the rising edge, advance the model, idle the controls, and return
  // at the following falling edge.
  task automatic clockStep();
    @(posedge clk);
    updateModel();
    #1;
    idleInputs();
    @(negedge clk);
  endtask

  // One directed or random cycle: drive, check against model, clock.
  task automatic applyStimulus(input string tag,
      input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
      input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
      input logic ie, input logic [AW-1:0] ia, input logic fl,
      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    iss_en = ie;  iss_addr = ia;  flush = fl;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    checkAgainstModel(tag);
    clockStep();
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    idleInputs();
    resetModel();
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset.rs1_data", rs1_data, 32'h0);
    checkOutput("reset.rs2_busy", XLEN'(rs2_busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Mid-cycle asynchronous reset wipes data and busy flags immediately
    applyStimulus("pre_rst", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 5'd6, 0, 5'd5, 5'd6);
    #1;
    checkOutput("pre_rst.x5", rs1_data, 32'hDEADBEEF);
    checkOutput("pre_rst.x6_busy", XLEN'(rs2_busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async.x5", rs1_data, 32'h0);
    checkOutput("rst_async.x6_busy", XLEN'(rs2_busy), 32'h0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // x0 protection
    applyStimulus("x0", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 5'd0, 0, 5'd0, 5'd0);
    #1;
    checkOutput("x0.data", rs1_data, 32'h0);
    checkOutput("x0.busy", XLEN'(rs1_busy), 32'h0);

    // Write collision: port 1 wins
    applyStimulus("collide", 1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 0, 0, 0, 5'd0, 5'd0);
    rs1_addr = 5'd7; #1;
    checkOutput("collide.x7", rs1_data, 32'h22222222);

    // Scoreboard set / set-beats-clear / clear
    applyStimulus("iss_x3", 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 5'd0, 5'd0);
    rs1_addr = 5'd3; #1;
    checkOutput("sb.set", XLEN'(rs1_busy), 32'h1);
    applyStimulus("sb_both", 1, 5'd3, 32'h33, 0, 0, 0, 1, 5'd3, 0, 5'd0, 5'd0);
    rs1_addr = 5'd3; #1;
    checkOutput("sb.set_wins", XLEN'(rs1_busy), 32'h1);
    applyStimulus("sb_clr", 0, 0, 0, 1, 5'd3, 32'h44, 0, 0, 0, 5'd0, 5'd0);
    rs1_addr = 5'd3; #1;
    checkOutput("sb.clear", XLEN'(rs1_busy), 32'h0);
    checkOutput("sb.clear_data", rs1_data, 32'h44);

    // Flush overrides a same-cycle issue
    applyStimulus("iss_x4", 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 5'd0, 5'd0);
    applyStimulus("iss_x9", 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd0, 5'd0);
    applyStimulus("iss_x12", 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 5'd4, 5'd9);
    applyStimulus("flush", 0, 0, 0, 0, 0, 0, 1, 5'd4, 1, 5'd4, 5'd9);
    rs1_addr = 5'd4; rs2_addr = 5'd9; #1;
    checkOutput("flush.x4", XLEN'(rs1_busy), 32'h0);
    checkOutput("flush.x9", XLEN'(rs2_busy), 32'h0);
    rs1_addr = 5'd12; #1;
    checkOutput("flush.x12", XLEN'(rs1_busy), 32'h0);
    @(negedge clk);

    // Same-cycle read of a register being written
    rs2_addr = 5'd8;
    wr0_en = 1; wr0_addr = 5'd8; wr0_data = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass.same", rs2_data, 32'hCAFEF00D);
`else
    checkOutput("bypass.same", rs2_data, 32'h0);
`endif
    checkOutput("bypass.busy", XLEN'(rs2_busy), 32'h0);
    clockStep();
    #1;
    checkOutput("bypass.next", rs2_data, 32'hCAFEF00D);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
        1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), XLEN'($urandom),
        1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), XLEN'($urandom),
        1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
        1'($urandom_range(0, 15) == 0),
        AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
    end
    rs1_addr = 5'd0; rs2_addr = 5'd1; #1;
    checkAgainstModel("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_regfile_sb
